cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache in the pipelined LC-3b core.
- Sits between the two cache miss/writeback interfaces and the `mem_*` port of the `mp3` top.
- Grants one whole-line transaction at a time.
  - Round-robin priority when both caches request together.
  - No priority needed when only one requests.
- Keeps saturating per-port grant counters for performance analysis.

Parameters:
- LINE_WIDTH, 128, cache line width in bits on all data buses.
- CNT_WIDTH, 16, width of each grant counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  16  I-cache line address (lc3b_word)
- i_rdata  out  LINE_WIDTH  line data to I-cache, valid when i_resp
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_address  in  16  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache writeback data
- d_rdata  out  LINE_WIDTH  line data to D-cache, valid when d_resp
- d_resp  out  1  D-cache transaction complete
- mem_read  out  1  physical memory read strobe
- mem_write  out  1  physical memory write strobe
- mem_address  out  16  physical memory address
- mem_wdata  out  LINE_WIDTH  physical memory write data
- mem_rdata  in  LINE_WIDTH  physical memory read data
- mem_resp  in  1  physical memory transaction complete
- cnt_clear  in  1  synchronous clear of both grant counters
- i_grant_cnt  out  CNT_WIDTH  I-cache grants since reset or clear
- d_grant_cnt  out  CNT_WIDTH  D-cache grants since reset or clear

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DRAIN. Register last_grant: 0 = I, 1 = D.
- Reset (async) values:
  - state = IDLE; last_grant = 1 (so I-cache wins the first tie).
  - Both counters = 0.
  - All mem_* strobes, i_resp and d_resp = 0.
- Pending requests:
  - i_pend = i_read.
  - d_pend = d_read | d_write.
  - d_read & d_write both high is illegal; in that case d_write wins.
- IDLE transitions:
  - Only i_pend -> SERVE_I.
  - Only d_pend -> SERVE_D.
  - Both pending -> serve the port opposite last_grant.
  - On the grant edge: update last_grant and increment that port's counter.
- No memory strobe is driven in IDLE. Latency is 1 cycle from request to mem strobe.
- SERVE_I (combinational outputs):
  - mem_read = i_read; mem_address = i_address; mem_write = 0.
  - i_rdata = mem_rdata; i_resp = mem_resp.
- SERVE_D (combinational outputs):
  - mem_read = d_read & ~d_write; mem_write = d_write.
  - mem_address = d_address; mem_wdata = d_wdata.
  - d_rdata = mem_rdata; d_resp = mem_resp.
- Outside the owning state, rdata outputs = mem_rdata and resp = 0. mem_wdata = d_wdata always.
- End of a transaction: mem_resp in SERVE_x -> DRAIN at the next edge.
  - DRAIN drives no strobes and lasts exactly 1 cycle, then IDLE.
  - DRAIN lets the cache deassert its request, so a stale request is not re-granted.
  - Back-to-back turnaround is therefore resp, DRAIN, IDLE, grant.
- Request drops before mem_resp (abort):
  - Strobes fall with the request.
  - The FSM stays in SERVE_x until the request returns or mem_resp arrives.
  - A mem_resp with the request low still goes to DRAIN; the resp is forwarded, but the cache ignores it.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clear has priority over an increment in the same cycle, giving 0.
- Async reset mid-transaction:
  - Strobes drop immediately and state returns to IDLE.
  - Memory is assumed to be reset by the same signal.
- mem_resp in IDLE or DRAIN is ignored.

Decomposition:
- lc3b_types additions:
  - lc3b_line (logic [127:0]).
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, DRAIN}.
- Sub-module sat_counter #(WIDTH), instantiated twice.
  - Inputs: clk, reset, clear, inc. Output: count.

Test Plan:
- I-only read:
  - i_read at addr 0x1230; mem_resp 3 cycles after mem_read with rdata 0xDEAD...BEEF.
  - Required: mem_read high from cycle+1, i_rdata matches, i_resp exactly 1 cycle, i_grant_cnt = 1, DRAIN cycle with no strobe.
- D writeback:
  - d_write at 0x4000 with wdata 0x0123...CDEF.
  - Required: mem_write = 1, mem_read = 0, mem_wdata/address pass through, d_resp forwarded, d_grant_cnt = 1.
- Simultaneous requests from reset:
  - i_read and d_read asserted together and held.
  - Required grant order I, D, I, D, with one IDLE+DRAIN gap between grants. After 4 grants both counters = 2.
- Abort:
  - d_read dropped 1 cycle after grant; no mem_resp for 5 cycles, then mem_resp.
  - Required: mem_read low while dropped, FSM holds SERVE_D, DRAIN then IDLE, no spurious I grant before DRAIN ends.
- Counter saturation and clear:
  - Force 65536 I grants (or CNT_WIDTH = 4 and 17 grants).
  - Required: i_grant_cnt stops at all-ones. cnt_clear together with a grant gives 0.
- Async reset mid-SERVE_I:
  - reset asserted between clock edges.
  - Required: mem_read and i_resp go low immediately, counters = 0, first grant after release goes to I on a tie.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types for the I/D cache memory-port arbiter
package cache_mem_arbiter_pkg;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DRAIN
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_sat_counter.sv
// rtl/cache_mem_arbiter_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin owner of the single memory port for I- and D-cache line transactions
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [15:0]           i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [15:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [15:0]           mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  input  logic                  cnt_clear,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       i_pend, d_pend;
  logic       i_inc, d_inc;

  assign i_pend    = i_read;
  assign d_pend    = d_read | d_write;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_wdata = d_wdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    i_inc        = 1'b0;
    d_inc        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time is served.
        if (i_pend && (!d_pend || (last_grant_q == GRANT_D))) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          i_inc        = 1'b1;
        end else if (d_pend) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          d_inc        = 1'b1;
        end
      end
      SERVE_I: begin
        mem_read    = i_read;
        mem_address = i_address;
        i_resp      = mem_resp;
        if (mem_resp) begin
          state_d = DRAIN;
        end
      end
      SERVE_D: begin
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        d_resp      = mem_resp;
        if (mem_resp) begin
          state_d = DRAIN;
        end
      end
      // One dead cycle so the finished cache can drop its request before IDLE samples it.
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_i_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (i_inc),
    .count (i_grant_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (d_inc),
    .count (d_grant_cnt)
  );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for the cache memory-port arbiter
module tb_cache_mem_arbiter;

  localparam int LW = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic i_read, d_read, d_write, cnt_clear;
  logic [15:0] i_address, d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic i_resp, d_resp, mem_read, mem_write, mem_resp;
  logic [15:0] mem_address;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt;

  logic auto_en = 1'b1;
  logic auto_resp = 1'b0;
  logic man_resp = 1'b0;
  logic [LW-1:0] auto_rdata = '0;
  logic [LW-1:0] man_rdata = '0;
  int lat = 3;
  bit lat_rand = 1'b0;

  assign mem_resp  = auto_en ? auto_resp : man_resp;
  assign mem_rdata = auto_en ? auto_rdata : man_rdata;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .cnt_clear(cnt_clear), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  typedef struct {
    bit            is_wr;
    logic [LW-1:0] data;
  } d_exp_t;

  logic [LW-1:0] exp_i[$];
  d_exp_t        exp_d[$];
  logic [LW-1:0] phys[int];
  logic [LW-1:0] ref_img[int];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [LW-1:0] pattern(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  function automatic logic [LW-1:0] ref_val(input logic [15:0] a);
    if (ref_img.exists(int'(a))) return ref_img[int'(a)];
    return pattern(a);
  endfunction

  function automatic logic [LW-1:0] phys_val(input logic [15:0] a);
    if (phys.exists(int'(a))) return phys[int'(a)];
    return pattern(a);
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Memory slave: answers a held strobe after lat cycles with one resp pulse.
  initial begin : responder
    logic          s_rd, s_wr;
    logic [15:0]   s_a;
    logic [LW-1:0] s_wd;
    int            cnt;
    bit            just;
    cnt  = 0;
    just = 1'b0;
    forever begin
      @(negedge clk);
      s_rd = mem_read;
      s_wr = mem_write;
      s_a  = mem_address;
      s_wd = mem_wdata;
      @(posedge clk);
      #1;
      auto_resp = 1'b0;
      if (!auto_en || reset || !(s_rd || s_wr) || just) begin
        cnt  = 0;
        just = 1'b0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          if (s_wr) phys[int'(s_a)] = s_wd;
          else auto_rdata = phys_val(s_a);
          auto_resp = 1'b1;
          just = 1'b1;
          cnt = 0;
          if (lat_rand) lat = $urandom_range(1, 4);
        end
      end
    end
  end

  initial begin : monitor
    logic [LW-1:0] e;
    d_exp_t        de;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_read || mem_write) chk("strobe_excl", {127'b0, mem_read & mem_write}, '0);
        if (mem_write) chk("mem_wdata", mem_wdata, d_wdata);
        if (i_resp) begin
          if (exp_i.size() == 0) fail_now("i_resp_unexpected");
          else begin
            e = exp_i.pop_front();
            chk("i_rdata", i_rdata, e);
          end
        end
        if (d_resp) begin
          if (exp_d.size() == 0) fail_now("d_resp_unexpected");
          else begin
            de = exp_d.pop_front();
            chk("d_kind", {127'b0, mem_write}, {127'b0, de.is_wr});
            if (!de.is_wr) chk("d_rdata", d_rdata, de.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    fail_now("global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  task automatic wait_resp(input bit port_d, input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (port_d ? d_resp : i_resp) break;
    end
    if (k == 100) fail_now(name);
  endtask

  task automatic do_i(input logic [15:0] a);
    @(posedge clk); #1;
    i_address = a;
    i_read = 1'b1;
    exp_i.push_back(ref_val(a));
    wait_resp(1'b0, "i_timeout");
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic do_d(input logic [15:0] a, input bit wr, input logic [LW-1:0] wd, input bit both);
    d_exp_t de;
    @(posedge clk); #1;
    d_address = a;
    d_wdata = wd;
    d_write = wr;
    d_read = !wr || both;
    de.is_wr = wr;
    de.data = ref_val(a);
    exp_d.push_back(de);
    if (wr) ref_img[int'(a)] = wd;
    wait_resp(1'b1, "d_timeout");
    @(posedge clk); #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin : main
    logic [LW-1:0] w;
    d_exp_t        de;
    int gcount, resps, low_run, owner;
    bit prev, strobe;
    reset = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; cnt_clear = 0;
    i_address = '0; d_address = '0; d_wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_read", {127'b0, mem_read}, '0);
    chk("rst_mem_write", {127'b0, mem_write}, '0);
    chk("rst_i_resp", {127'b0, i_resp}, '0);
    chk("rst_d_resp", {127'b0, d_resp}, '0);
    chk("rst_i_cnt", i_grant_cnt, '0);
    chk("rst_d_cnt", d_grant_cnt, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // I-only read
    w = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    phys[16'h1230] = w;
    ref_img[16'h1230] = w;
    @(posedge clk); #1;
    i_address = 16'h1230; i_read = 1'b1; exp_i.push_back(ref_val(16'h1230));
    @(negedge clk);
    chk("t1_idle_no_strobe", {127'b0, mem_read}, '0);
    @(negedge clk);
    chk("t1_mem_read", {127'b0, mem_read}, 1);
    chk("t1_mem_write", {127'b0, mem_write}, '0);
    chk("t1_addr", mem_address, 16'h1230);
    wait_resp(1'b0, "t1_timeout");
    @(negedge clk);
    chk("t1_drain_no_strobe", {127'b0, mem_read | mem_write}, '0);
    chk("t1_resp_one_cycle", {127'b0, i_resp}, '0);
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("t1_i_cnt", i_grant_cnt, 1);

    // D writeback then read-back
    lat = 2;
    w = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    d_address = 16'h4000; d_wdata = w; d_write = 1'b1; d_read = 1'b0;
    de.is_wr = 1'b1; de.data = '0; exp_d.push_back(de);
    ref_img[16'h4000] = w;
    @(negedge clk);
    @(negedge clk);
    chk("t2_mem_write", {127'b0, mem_write}, 1);
    chk("t2_mem_read", {127'b0, mem_read}, '0);
    chk("t2_addr", mem_address, 16'h4000);
    chk("t2_wdata", mem_wdata, w);
    wait_resp(1'b1, "t2_timeout");
    @(posedge clk); #1;
    d_write = 1'b0;
    @(negedge clk);
    chk("t2_d_cnt", d_grant_cnt, 1);
    do_d(16'h4000, 1'b0, '0, 1'b0);

    // Simultaneous requests from reset: I, D, I, D
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    i_address = 16'h0100; d_address = 16'h4000; i_read = 1'b1; d_read = 1'b1; d_write = 1'b0;
    for (int n = 0; n < 2; n++) begin
      exp_i.push_back(ref_val(16'h0100));
      de.is_wr = 1'b0; de.data = ref_val(16'h4000); exp_d.push_back(de);
    end
    gcount = 0; resps = 0; low_run = 0; prev = 1'b0;
    for (int k = 0; k < 80 && resps < 4; k++) begin
      @(negedge clk);
      strobe = mem_read | mem_write;
      if (strobe && !prev) begin
        owner = (mem_address == 16'h4000) ? 1 : 0;
        chk($sformatf("tie_owner%0d", gcount), owner, gcount % 2);
        if (gcount > 0) chk($sformatf("tie_gap%0d", gcount), low_run, 2);
        gcount++;
      end
      low_run = strobe ? 0 : low_run + 1;
      prev = strobe;
      if (i_resp || d_resp) resps++;
    end
    if (resps < 4) fail_now("tie_timeout");
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
    chk("tie_i_cnt", i_grant_cnt, 2);
    chk("tie_d_cnt", d_grant_cnt, 2);

    // Abort: D read drops after grant, I waits until DRAIN ends
    @(posedge clk); #1;
    auto_en = 1'b0; man_resp = 1'b0; man_rdata = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_5A5A;
    d_address = 16'h4010; d_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ab_granted", {127'b0, mem_read}, 1);
    @(posedge clk); #1;
    d_read = 1'b0; i_address = 16'h0200; i_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("ab_strobe_low%0d", k), {127'b0, mem_read | mem_write}, '0);
    end
    @(posedge clk); #1;
    man_resp = 1'b1;
    de.is_wr = 1'b0; de.data = man_rdata; exp_d.push_back(de);
    @(negedge clk);
    chk("ab_resp_fwd", {127'b0, d_resp}, 1);
    chk("ab_no_i_resp", {127'b0, i_resp}, '0);
    @(posedge clk); #1;
    man_resp = 1'b0; auto_en = 1'b1; lat = 1;
    exp_i.push_back(ref_val(16'h0200));
    @(negedge clk);
    chk("ab_drain", {127'b0, mem_read}, '0);
    @(negedge clk);
    chk("ab_idle", {127'b0, mem_read}, '0);
    @(negedge clk);
    chk("ab_i_grant", {127'b0, mem_read}, 1);
    chk("ab_i_addr", mem_address, 16'h0200);
    wait_resp(1'b0, "ab_timeout");
    @(posedge clk); #1;
    i_read = 1'b0;

    // Saturation, then clear racing a grant
    @(posedge clk); #1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    for (int n = 0; n < 17; n++) do_i(16'h0010 * 16'(n % 4));
    @(negedge clk);
    chk("sat_i_cnt", i_grant_cnt, 15);
    @(posedge clk); #1;
    i_address = 16'h0300; i_read = 1'b1; exp_i.push_back(ref_val(16'h0300));
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    @(negedge clk);
    chk("clr_granted", {127'b0, mem_read}, 1);
    chk("clr_vs_grant", i_grant_cnt, '0);
    wait_resp(1'b0, "clr_timeout");
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("clr_d_cnt", d_grant_cnt, '0);

    // Async reset in the middle of SERVE_I
    @(posedge clk); #1;
    auto_en = 1'b0; man_rdata = 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC;
    i_address = 16'h0400; i_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ar_granted", {127'b0, mem_read}, 1);
    @(posedge clk); #1;
    man_resp = 1'b1; exp_i.push_back(man_rdata);
    @(negedge clk);
    chk("ar_resp_before", {127'b0, i_resp}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_mem_read", {127'b0, mem_read}, '0);
    chk("ar_i_resp", {127'b0, i_resp}, '0);
    chk("ar_i_cnt", i_grant_cnt, '0);
    chk("ar_d_cnt", d_grant_cnt, '0);
    @(posedge clk); #1;
    man_resp = 1'b0; reset = 1'b0; auto_en = 1'b1; lat = 2;
    d_address = 16'h4020; d_read = 1'b1;
    exp_i.push_back(ref_val(16'h0400));
    @(negedge clk);
    @(negedge clk);
    chk("ar_tie_i_read", {127'b0, mem_read}, 1);
    chk("ar_tie_i_addr", mem_address, 16'h0400);
    @(posedge clk); #1;
    d_read = 1'b0;
    wait_resp(1'b0, "ar_timeout");
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("ar_i_cnt_after", i_grant_cnt, 1);

    // Randomized concurrent traffic
    @(posedge clk); #1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    lat_rand = 1'b1;
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_i(16'h0010 * 16'($urandom_range(0, 15)));
        end
      end
      begin
        bit wr;
        for (int n = 0; n < 12; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          wr = 1'($urandom_range(0, 1));
          do_d(16'h4000 + 16'h0010 * 16'($urandom_range(0, 7)), wr,
               {$urandom, $urandom, $urandom, $urandom}, wr && ($urandom_range(0, 3) == 0));
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("rnd_i_cnt", i_grant_cnt, 12);
    chk("rnd_d_cnt", d_grant_cnt, 12);
    chk("rnd_i_queue_empty", exp_i.size(), 0);
    chk("rnd_d_queue_empty", exp_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
